// File: rtl/prog_loader_pkg.sv
// Shared types for the instruction-memory program loader.
package prog_loader_pkg;

  localparam int unsigned StateWidth = 3;
  localparam int unsigned CountPad   = 1;

  typedef enum logic [StateWidth-1:0] {
    StIdle,
    StLoad,
    StDrain,
    StStart,
    StRun,
    StDone
  } state_e;

  // One extra bit so a full memory's word count is representable.
  function automatic int unsigned count_width(input int unsigned addr_width);
    return addr_width + CountPad;
  endfunction

endpackage

// File: rtl/run_watchdog.sv
// Counts cycles while enabled; flags expiry on the last allowed cycle.
module run_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rstn,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q;

  assign expired = enable && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && !expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Streams a program into instruction memory, starts the CPU and reports completion.
// Optional RUN watchdog enabled by defining RUN_TIMEOUT_EN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 10,
  parameter int unsigned MEM_DEPTH      = 8,
  parameter int unsigned ADDR_WIDTH     = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_address,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic                  cpu_start,
  input  logic                  cpu_done,
  output logic                  busy,
  output logic [ADDR_WIDTH:0]   loaded_count,
  output logic                  load_err,
  output logic                  run_done,
  output logic                  timeout
);

  localparam int unsigned CntW = count_width(ADDR_WIDTH);
  localparam logic [CntW-1:0] LastSlot = CntW'(MEM_DEPTH - 1);

  state_e                state_q;
  logic [CntW-1:0]       cnt_q;
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  start_q;
  logic                  err_q;
  logic                  done_q;
  logic                  tmo_q;
  logic                  expired;

`ifdef RUN_TIMEOUT_EN
  run_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_run_watchdog (
    .clk    (clk),
    .rstn   (rstn),
    .enable (state_q == StRun),
    .clear  (state_q != StRun),
    .expired(expired)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
  assign expired = 1'b0;
`endif

  assign s_ready      = (state_q == StLoad) || (state_q == StDrain);
  assign busy         = (state_q != StIdle);
  assign wr_en        = wr_en_q;
  assign wr_address   = wr_addr_q;
  assign data_in      = data_q;
  assign cpu_start    = start_q;
  assign loaded_count = cnt_q;
  assign load_err     = err_q;
  assign run_done     = done_q;
  assign timeout      = tmo_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      data_q    <= '0;
      start_q   <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (s_valid) begin
            state_q <= StLoad;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
          end
        end
        StLoad: begin
          // s_ready is high here, so s_valid alone marks an accepted beat.
          if (s_valid) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= cnt_q[ADDR_WIDTH-1:0];
            data_q    <= s_data;
            cnt_q     <= cnt_q + 1'b1;
            if (s_last) begin
              state_q <= StStart;
            end else if (cnt_q == LastSlot) begin
              err_q   <= 1'b1;
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          if (s_valid && s_last) begin
            state_q <= StIdle;
          end
        end
        StStart: begin
          start_q <= 1'b1;
          state_q <= StRun;
        end
        StRun: begin
          if (cpu_done) begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end else if (expired) begin
            tmo_q   <= 1'b1;
            state_q <= StIdle;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
Writer-side companion to the CPU's instruction fetch path. It accepts a valid/ready stream of instruction words and writes them into instruction memory through that memory's write port. It then pulses the CPU start, waits for the CPU done, and reports completion. It sits beside the CPU in the top level and drives the instruction memory write port, which is otherwise tied off.

Parameters:
DATA_WIDTH, 10, instruction word width; matches instruction memory.
MEM_DEPTH, 8, instruction memory depth in words.
ADDR_WIDTH, 3, memory address width; MEM_DEPTH <= 2**ADDR_WIDTH.
TIMEOUT_CYCLES, 1024, RUN watchdog limit; used only with RUN_TIMEOUT_EN.

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
s_valid  in  1  stream word valid
s_data  in  DATA_WIDTH  instruction word
s_last  in  1  final word of program, qualified by s_valid
s_ready  out  1  loader accepts a word this cycle
wr_en  out  1  instruction memory write enable
wr_address  out  ADDR_WIDTH  instruction memory write address
data_in  out  DATA_WIDTH  instruction memory write data
cpu_start  out  1  one-cycle start pulse to CPU
cpu_done  in  1  CPU completion (level or pulse)
busy  out  1  high in any state other than IDLE
loaded_count  out  ADDR_WIDTH+1  words written in the last load
load_err  out  1  program overflowed MEM_DEPTH; sticky until next load
run_done  out  1  one-cycle pulse when CPU completes
timeout  out  1  watchdog expired; sticky until next load

Behaviour:
- Clock and reset: single clock. Reset is asynchronous and active-low on rstn.
- Reset values: all outputs are 0, the state is IDLE and the address counter is 0. A reset in any state aborts immediately to IDLE. Memory contents are left untouched.
- Handshake: a beat transfers when s_valid and s_ready are both high. s_ready is high only in LOAD and DRAIN. The source holds s_data and s_last while s_valid is high and s_ready is low.
- States: IDLE, LOAD, DRAIN, START, RUN, DONE.
- IDLE:
  - s_ready is 0.
  - s_valid high moves to LOAD on the next cycle, clearing the address counter, loaded_count, load_err and timeout.
  - The first word is accepted in LOAD, not in IDLE.
- LOAD:
  - Each beat accepted at cycle N produces wr_en=1 at N+1, with wr_address set to the counter value and data_in set to the word. All three outputs are registered. The counter and loaded_count then increment.
  - An accepted beat with s_last=1 moves to START.
  - If the beat written to address MEM_DEPTH-1 has s_last=1, the load is legal and moves to START.
  - If the beat written to address MEM_DEPTH-1 has s_last=0, the FSM sets load_err and moves to DRAIN.
  - The counter never wraps, so no write is ever issued to an address at or above MEM_DEPTH.
- DRAIN:
  - Accepts and discards beats; no writes are issued.
  - An accepted s_last moves to IDLE. The CPU is not started.
- START:
  - Entered the cycle after the last accepted beat, which is also the cycle in which that beat's wr_en is high.
  - cpu_start=1 for exactly one cycle in the next cycle, so start asserts at N+2 relative to acceptance of the last beat.
  - cpu_done is ignored in START.
- RUN:
  - Waits for cpu_done=1, which is sampled only in RUN.
  - When sampled high, moves to DONE.
- DONE: run_done=1 for one cycle, then IDLE. cpu_done still high on return to IDLE has no effect.
- Minimum program: s_last on the first beat is a one-word load with loaded_count=1.
- Simultaneous events: s_valid arriving while in START, RUN or DONE is back-pressured (s_ready=0) until the FSM is back in LOAD.
- loaded_count holds its value after the load until the next entry to LOAD.

Optional Feature:
RUN_TIMEOUT_EN
- Defined: a counter runs in RUN. If cpu_done has not been seen after TIMEOUT_CYCLES cycles, timeout is set sticky, the FSM returns to IDLE and run_done is not pulsed.
- Undefined: RUN waits indefinitely and timeout is tied to 0. The port remains present in both builds.

Decomposition:
- Package prog_loader_pkg:
  - state enum (IDLE, LOAD, DRAIN, START, RUN, DONE) and its encoding width;
  - a localparam for the count width, ADDR_WIDTH+1.
- Sub-module run_watchdog (enable, clear, expired), generated only under RUN_TIMEOUT_EN.
- The FSM, counter and write registers stay in prog_loader.

Test Plan:
- Load 3 words 0x101, 0x2A5, 0x3FF with s_last on the third:
  - wr_en pulses write addresses 0..2 with matching data;
  - cpu_start fires 2 cycles after the third acceptance;
  - loaded_count=3.
- Full 8-word load with s_last on word 8: addresses 0..7 are written, load_err=0, cpu_start fires once. Then cpu_done=1 gives run_done one cycle later and busy=0.
- Load 10 words with s_last on word 10:
  - 8 writes occur, words 9–10 are discarded;
  - load_err=1, no cpu_start, return to IDLE.
- Toggle s_valid (1,0,1,0) during LOAD: only handshaked beats write, addresses stay contiguous, s_data is held across stalls.
- Assert rstn=0 mid-LOAD after 2 writes: all outputs are 0 asynchronously. A fresh load afterwards restarts at address 0.
- With RUN_TIMEOUT_EN and TIMEOUT_CYCLES=16, hold cpu_done=0: timeout=1 after 16 RUN cycles, no run_done, FSM in IDLE.
